// File: rtl/display_drop_pkg.sv
// Shared state codes and 7-segment glyphs for the display drop controller.
// Segment words are {g,f,e,d,c,b,a}; bit0 is segment a.
package display_drop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_COLD = 3'd1,
        ST_HOT  = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_O     = 7'b1011100;
    localparam logic [6:0] SEG_L     = 7'b0111000;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_R     = 7'b1010000;
    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_H     = 7'b1110110;
    localparam logic [6:0] SEG_T     = 7'b1111000;

    localparam logic [27:0] MSG_IDLE = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
    localparam logic [27:0] MSG_COLD = {SEG_C, SEG_O, SEG_L, SEG_D};
    localparam logic [27:0] MSG_DROP = {SEG_D, SEG_R, SEG_O, SEG_P};
    localparam logic [27:0] MSG_HOT  = {SEG_BLANK, SEG_H, SEG_O, SEG_T};

    // Returns {seg1, seg2, seg3, seg4} for a state.
    function automatic logic [27:0] glyphs(input state_t s);
        logic [27:0] g;
        case (s)
            ST_COLD: g = MSG_COLD;
            ST_HOT:  g = MSG_HOT;
            ST_DROP: g = MSG_DROP;
            ST_HOLD: g = MSG_DROP;
            default: g = MSG_IDLE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/display_drop_ctrl_temp_classifier.sv
// Hot/cold classifier with hysteresis and settle filtering.
// Ports: clk, rst, t_act, t_lim, t_valid in; hot_flag, primed out.
module temp_classifier #(
    parameter int TW     = 16,
    parameter int HYST   = 2,
    parameter int SETTLE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] t_act,
    input  logic [TW-1:0] t_lim,
    input  logic          t_valid,
    output logic          hot_flag,
    output logic          primed
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [TW:0]   act_x;
    logic [TW:0]   act_h;
    logic [TW:0]   lim_x;
    logic          hot_set;
    logic          hot_clr;
    logic          opposite;
    logic [CW-1:0] cnt;

    // One extra bit keeps t_act+HYST from wrapping.
    assign act_x    = {1'b0, t_act};
    assign lim_x    = {1'b0, t_lim};
    assign act_h    = act_x + (TW+1)'(HYST);
    assign hot_set  = act_x > lim_x;
    assign hot_clr  = act_h < lim_x;
    assign opposite = hot_flag ? hot_clr : hot_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            hot_flag <= 1'b0;
            primed   <= 1'b0;
            cnt      <= '0;
        end else if (t_valid) begin
            if (!primed) begin
                // First sample loads the flag directly.
                primed   <= 1'b1;
                hot_flag <= hot_set;
                cnt      <= '0;
            end else if (opposite) begin
                if (cnt == CW'(SETTLE - 1)) begin
                    hot_flag <= ~hot_flag;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // In-band or agreeing sample breaks the run.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/display_drop_ctrl.sv
// Drop controller: temperature-gated drop pulse with 4-digit status display.
// Ports: clk, rst, t_act/t_lim/t_valid, drop_en in; drop_activated,
// drop_abort, drops_done, state_o, seven_seg1..4 out (all registered).
module display_drop_ctrl
    import display_drop_pkg::*;
#(
    parameter int TW          = 16,
    parameter int HYST        = 2,
    parameter int SETTLE      = 3,
    parameter int DROP_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] t_act,
    input  logic [TW-1:0] t_lim,
    input  logic          t_valid,
    input  logic          drop_en,
    output logic          drop_activated,
    output logic          drop_abort,
    output logic [7:0]    drops_done,
    output logic [2:0]    state_o,
    output logic [6:0]    seven_seg1,
    output logic [6:0]    seven_seg2,
    output logic [6:0]    seven_seg3,
    output logic [6:0]    seven_seg4
);

    localparam int DW = $clog2(DROP_CYCLES + 1);

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_n;
    logic          drop_q;
    logic          rise;
    logic          abort_n;
    logic          done_n;
    logic          hot_flag;
    logic          primed;

    temp_classifier #(
        .TW     (TW),
        .HYST   (HYST),
        .SETTLE (SETTLE)
    ) u_cls (
        .clk      (clk),
        .rst      (rst),
        .t_act    (t_act),
        .t_lim    (t_lim),
        .t_valid  (t_valid),
        .hot_flag (hot_flag),
        .primed   (primed)
    );

    assign rise    = drop_en & ~drop_q;
    assign state_o = state;

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        abort_n = 1'b0;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (primed) state_n = hot_flag ? ST_HOT : ST_COLD;
            end
            ST_COLD: begin
                if (hot_flag) begin
                    state_n = ST_HOT;
                end else if (rise) begin
                    state_n = ST_DROP;
                    dcnt_n  = DW'(1);
                end
            end
            ST_DROP: begin
                if (hot_flag) begin
                    state_n = ST_HOT;
                    dcnt_n  = '0;
                    abort_n = 1'b1;
                end else if (dcnt == DW'(DROP_CYCLES)) begin
                    state_n = ST_HOLD;
                    dcnt_n  = '0;
                    done_n  = 1'b1;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!drop_en) state_n = hot_flag ? ST_HOT : ST_COLD;
            end
            ST_HOT: begin
                if (!hot_flag) state_n = ST_COLD;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            dcnt           <= '0;
            drop_q         <= 1'b0;
            drop_activated <= 1'b0;
            drop_abort     <= 1'b0;
            drops_done     <= 8'd0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= MSG_IDLE;
        end else begin
            state          <= state_n;
            dcnt           <= dcnt_n;
            drop_q         <= drop_en;
            drop_activated <= (state_n == ST_DROP);
            drop_abort     <= abort_n;
            if (done_n && drops_done != 8'hFF) begin
                drops_done <= drops_done + 8'd1;
            end
            // Display follows the current state register, one cycle late.
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= glyphs(state);
        end
    end

endmodule

// File: tb/tb_display_drop_ctrl.sv
// Directed self-checking bench for display_drop_ctrl.
// Runs with TW=16, HYST=2, SETTLE=3, DROP_CYCLES=4.
module tb_display_drop_ctrl;

    localparam logic [27:0] G_DASH = {4{7'b1000000}};
    localparam logic [27:0] G_COLD = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
    localparam logic [27:0] G_DROP = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
    localparam logic [27:0] G_HOT  = {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        t_valid;
    logic        drop_en;
    logic        drop_activated;
    logic        drop_abort;
    logic [7:0]  drops_done;
    logic [2:0]  state_o;
    logic [6:0]  seven_seg1;
    logic [6:0]  seven_seg2;
    logic [6:0]  seven_seg3;
    logic [6:0]  seven_seg4;
    logic [27:0] segs;

    int n_cmp = 0;
    int n_err = 0;

    assign segs = {seven_seg1, seven_seg2, seven_seg3, seven_seg4};

    display_drop_ctrl #(
        .TW          (16),
        .HYST        (2),
        .SETTLE      (3),
        .DROP_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .t_act          (t_act),
        .t_lim          (t_lim),
        .t_valid        (t_valid),
        .drop_en        (drop_en),
        .drop_activated (drop_activated),
        .drop_abort     (drop_abort),
        .drops_done     (drops_done),
        .state_o        (state_o),
        .seven_seg1     (seven_seg1),
        .seven_seg2     (seven_seg2),
        .seven_seg3     (seven_seg3),
        .seven_seg4     (seven_seg4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One valid sample followed by one idle cycle.
    task automatic sample(input logic [15:0] a);
        t_act   = a;
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        drop_en = 1'b0;
        t_valid = 1'b0;
        t_act   = 16'd0;
        t_lim   = 16'd100;
        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_act", 32'(drop_activated), 32'd0);
        chk("rst_abort", 32'(drop_abort), 32'd0);
        chk("rst_done", 32'(drops_done), 32'd0);
        chk("rst_segs", 32'(segs), 32'(G_DASH));
        rst = 1'b0;

        // Edge in IDLE is ignored.
        drop_en = 1'b1;
        tick();
        tick();
        chk("idle_ignore", 32'(state_o), 32'd0);
        drop_en = 1'b0;
        tick();

        // Basic drop from COLD.
        sample(16'd50);
        chk("to_cold", 32'(state_o), 32'd1);
        tick();
        chk("segs_cold", 32'(segs), 32'(G_COLD));
        drop_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("drop_act_on", 32'(drop_activated), 32'd1);
            chk("drop_state", 32'(state_o), 32'd3);
            tick();
        end
        chk("drop_act_off", 32'(drop_activated), 32'd0);
        chk("hold_state", 32'(state_o), 32'd4);
        chk("done_1", 32'(drops_done), 32'd1);
        tick();
        chk("hold_stay", 32'(state_o), 32'd4);
        chk("segs_hold", 32'(segs), 32'(G_DROP));
        drop_en = 1'b0;
        tick();
        chk("hold_exit", 32'(state_o), 32'd1);

        // Hysteresis / settle.
        sample(16'd101);
        sample(16'd99);
        sample(16'd101);
        sample(16'd101);
        chk("settle_reset", 32'(state_o), 32'd1);
        sample(16'd101);
        chk("to_hot", 32'(state_o), 32'd2);
        tick();
        chk("segs_hot", 32'(segs), 32'(G_HOT));
        sample(16'd97);
        sample(16'd97);
        sample(16'd98);
        sample(16'd97);
        sample(16'd97);
        chk("hot_98", 32'(state_o), 32'd2);
        sample(16'd100);
        sample(16'd97);
        sample(16'd97);
        chk("hot_100", 32'(state_o), 32'd2);
        sample(16'd97);
        chk("to_cold2", 32'(state_o), 32'd1);

        // Abort a drop with a hot flag.
        sample(16'd101);
        sample(16'd101);
        chk("pre_abort", 32'(state_o), 32'd1);
        drop_en = 1'b1;
        tick();
        t_act   = 16'd101;
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        chk("abort_c2_act", 32'(drop_activated), 32'd1);
        chk("abort_c2_st", 32'(state_o), 32'd3);
        tick();
        chk("abort_act", 32'(drop_activated), 32'd0);
        chk("abort_pulse", 32'(drop_abort), 32'd1);
        chk("abort_state", 32'(state_o), 32'd2);
        chk("abort_done", 32'(drops_done), 32'd1);
        tick();
        chk("abort_clear", 32'(drop_abort), 32'd0);

        // drop_en held through HOT->COLD.
        sample(16'd97);
        sample(16'd97);
        sample(16'd97);
        chk("held_cold", 32'(state_o), 32'd1);
        tick();
        tick();
        chk("held_nodrop", 32'(state_o), 32'd1);
        chk("held_act", 32'(drop_activated), 32'd0);
        drop_en = 1'b0;
        tick();
        drop_en = 1'b1;
        tick();
        chk("retoggle_st", 32'(state_o), 32'd3);
        chk("retoggle_act", 32'(drop_activated), 32'd1);
        repeat (4) tick();
        chk("retoggle_hold", 32'(state_o), 32'd4);
        chk("done_2", 32'(drops_done), 32'd2);
        drop_en = 1'b0;
        tick();

        // Reset mid-drop.
        drop_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_act", 32'(drop_activated), 32'd0);
        chk("mrst_segs", 32'(segs), 32'(G_DASH));
        chk("mrst_state", 32'(state_o), 32'd0);
        chk("mrst_done", 32'(drops_done), 32'd0);
        rst = 1'b0;
        sample(16'd50);
        tick();
        tick();
        chk("post_rst_st", 32'(state_o), 32'd1);
        chk("post_rst_act", 32'(drop_activated), 32'd0);
        drop_en = 1'b0;
        tick();

        // Saturation of drops_done.
        for (int i = 0; i < 255; i++) begin
            drop_en = 1'b1;
            tick();
            repeat (4) tick();
            drop_en = 1'b0;
            tick();
        end
        chk("done_255", 32'(drops_done), 32'd255);
        drop_en = 1'b1;
        tick();
        repeat (4) tick();
        chk("sat_hold", 32'(state_o), 32'd4);
        chk("done_sat", 32'(drops_done), 32'd255);
        drop_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
